// File: rtl/control_medidor_pulsos.sv
// Gate-time controller for the pulse-counter frequency meter: opens an N-cycle window,
// counts synchronized rising edges of pulso, and publishes the count with a listo strobe.
module control_medidor_pulsos #(
  parameter int CICLOS_PUERTA = 1000,
  parameter int ANCHO         = 16,
  parameter int MODO_CONTINUO = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inicio,
  input  logic             parar,
  input  logic             pulso,
  output logic [ANCHO-1:0] conteo,
  output logic             listo,
  output logic             ocupado,
  output logic             desborde
);

  localparam int GW = $clog2(CICLOS_PUERTA);
  localparam logic [GW-1:0]    ULTIMO = GW'(CICLOS_PUERTA - 1);
  localparam logic [ANCHO-1:0] SAT    = '1;

  localparam logic [1:0] REPOSO   = 2'd0;
  localparam logic [1:0] ARMADO   = 2'd1;
  localparam logic [1:0] MIDIENDO = 2'd2;
  localparam logic [1:0] CERRANDO = 2'd3;

  logic             s1_q, s2_q, s3_q;
  logic [1:0]       estado_q, estado_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [ANCHO-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ANCHO-1:0] conteo_q, conteo_d;
  logic             desborde_q, desborde_d;
  logic             listo_q, listo_d;
  logic             flanco;

  // s1/s2 resolve metastability; s3 only delays s2 for the rising-edge compare
  assign flanco = s2_q & ~s3_q;

  always_comb begin
    estado_d   = estado_q;
    gate_d     = gate_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    conteo_d   = conteo_q;
    desborde_d = desborde_q;
    listo_d    = 1'b0;
    case (estado_q)
      REPOSO: if (inicio) estado_d = ARMADO;
      ARMADO: begin
        gate_d   = '0;
        acc_d    = '0;
        ovf_d    = 1'b0;
        estado_d = MIDIENDO;
      end
      MIDIENDO: begin
        if (flanco) begin
          if (acc_q == SAT) ovf_d = 1'b1;
          else              acc_d = acc_q + 1'b1;
        end
        if (gate_q == ULTIMO) estado_d = CERRANDO;
        else                  gate_d   = gate_q + 1'b1;
      end
      default: begin
        conteo_d   = acc_q;
        desborde_d = ovf_q;
        listo_d    = 1'b1;
        estado_d   = (MODO_CONTINUO != 0) ? ARMADO : REPOSO;
      end
    endcase
    // abort wins over the close/latch in the same cycle; the window is thrown away
    if (parar && estado_q != REPOSO) begin
      estado_d   = REPOSO;
      conteo_d   = conteo_q;
      desborde_d = desborde_q;
      listo_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      estado_q   <= REPOSO;
      gate_q     <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      conteo_q   <= '0;
      desborde_q <= 1'b0;
      listo_q    <= 1'b0;
    end else begin
      s1_q       <= pulso;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      estado_q   <= estado_d;
      gate_q     <= gate_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      conteo_q   <= conteo_d;
      desborde_q <= desborde_d;
      listo_q    <= listo_d;
    end
  end

  assign conteo   = conteo_q;
  assign desborde = desborde_q;
  assign listo    = listo_q;
  assign ocupado  = (estado_q != REPOSO);

endmodule

// File: doc/control_medidor_pulsos.md
# control_medidor_pulsos

Gate-time controller for the pulse-counter frequency meter. Uses the system clock as the timebase to open a measurement window of fixed length, counts rising edges of an external asynchronous signal during that window, and publishes the latched count with a one-cycle strobe. It sequences the divider/counter datapath (arm, gate, close, latch) and supports single-shot and continuous operation.

## Interface
- CICLOS_PUERTA, 1000: gate window length in clock cycles (N); legal range 2..2^20.
- ANCHO, 16: width of pulse count and result.
- MODO_CONTINUO, 0: 0 = one measurement per inicio; 1 = re-arm automatically after each result until parar.

- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, one reset.
- inicio  in  1  start request; sampled only in REPOSO.
- parar  in  1  abort request; sampled in any busy state.
- pulso  in  1  external signal, asynchronous to clock.
- conteo  out  ANCHO  latched edge count of the last completed window.
- listo  out  1  one-cycle strobe; conteo/desborde are new this cycle.
- ocupado  out  1  high in ARMADO, MIDIENDO, CERRANDO.
- desborde  out  1  count saturated in the last completed window.

## Operation
- Input path: pulso -> two-flop synchronizer s1,s2 -> delay flop s3; edge = s2 & ~s3. Pin-to-edge latency: 3 cycles. All three flops reset to 0.
- State machine, 2-bit encoding:
  - REPOSO: inicio=1 -> ARMADO; otherwise stay.
  - ARMADO (1 cycle): clear gate counter and accumulator, clear internal overflow flag -> MIDIENDO.
  - MIDIENDO (exactly N cycles): gate counter 0..N-1; each cycle with edge=1 increments accumulator. At gate count N-1 (that cycle's edge still counted) -> CERRANDO.
  - CERRANDO (1 cycle): conteo <= accumulator, desborde <= overflow flag, listo <= 1 (registered, visible next cycle) -> REPOSO, or ARMADO if MODO_CONTINUO=1.
- Edges detected in REPOSO, ARMADO or CERRANDO are discarded.
- Accumulator saturates at 2^ANCHO-1; any edge when saturated sets the overflow flag. No wrap-around.
- parar=1 in ARMADO/MIDIENDO/CERRANDO -> REPOSO next cycle; no listo; conteo and desborde keep previous values; continuous run ends. parar has priority over the CERRANDO latch in the same cycle (window discarded). parar in REPOSO has no effect.
- inicio while ocupado=1 is ignored (not queued).
- inicio and parar both high in REPOSO: parar ignored, measurement starts.
- reset (any state, including mid-window): next cycle state REPOSO, conteo=0, listo=0, ocupado=0, desborde=0, counters 0.

## Timing
- Reset values: conteo=0, listo=0, ocupado=0, desborde=0.
- Cycle 0 = inicio high in REPOSO. Cycle 1: ARMADO, ocupado=1. Cycles 2..N+1: MIDIENDO. Cycle N+2: CERRANDO. Cycle N+3: listo=1 for exactly one cycle, conteo/desborde valid, ocupado=0 (single-shot).
- conteo/desborde stable from cycle N+3 until the next listo or reset.
- Continuous mode: ocupado stays 1; listo strobes every N+2 cycles; dead time between windows = 2 cycles (CERRANDO, ARMADO).
- Counted edges: those whose pulso rise occurs at cycles -1..N-2 relative to cycle 0 + 2 after the 3-cycle pin latency, i.e. edge flag in cycles 2..N+1.

## Test plan
- N=100, ANCHO=8, pulso period 10 cycles, rises at cycles 3,13,23,… after inicio -> listo only at cycle 103, conteo=10, desborde=0, ocupado high cycles 1..102.
- N=100, ANCHO=4, pulso period 4 cycles -> conteo=15, desborde=1; next window with pulso period 20 -> conteo=5, desborde=0.
- pulso held 1 from before reset release, N=50 -> conteo=0, listo at cycle 53; inicio pulsed again at cycle 20 -> ignored, single listo.
- After a result conteo=10, start again, parar at cycle 50 -> ocupado=0 at cycle 51, no listo, conteo stays 10; reset at cycle 30 of a later window -> all outputs 0 next cycle, new inicio gives normal result.
- MODO_CONTINUO=1, N=20, steady pulso period 5 -> listo at cycles 23, 45, 67, each conteo=4; parar at cycle 50 -> no further listo, ocupado=0 at 51.
- parar and CERRANDO in same cycle (parar at cycle N+2) -> no listo, conteo unchanged, REPOSO next cycle.
